// File: rtl/negacyclic_mult.sv
// negacyclic_mult: streams in two length-N coefficient vectors p and u,
// computes z = p*u mod (x^N+1, Q) with N parallel multiply-accumulate
// lanes, and streams z out.
//
// Handshake rule for every stream: a beat transfers in the cycle where both
// vld and rdy are high at the rising clock edge. The producer holds its data
// and last flag stable while vld is high and rdy is low.
module negacyclic_mult #(
  parameter int N  = 4,
  parameter int QW = 5,
  parameter int UW = 2,
  parameter int Q  = 17
) (
  input  logic          clk,
  input  logic          s_rst,
  input  logic          p_vld,
  output logic          p_rdy,
  input  logic [QW-1:0] p,
  input  logic          p_last,
  input  logic          u_vld,
  output logic          u_rdy,
  input  logic [UW-1:0] u,
  input  logic          u_last,
  output logic          z_vld,
  input  logic          z_rdy,
  output logic [QW-1:0] z,
  output logic          z_last,
  output logic          err,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int LN = $clog2(N);
  // Products and sums are formed in a signed width wide enough that
  // acc + |p*u| never overflows.
  localparam int W = QW + UW + 2;
  localparam logic signed [W-1:0] Q_S = W'(Q);
  localparam logic [LN-1:0] LAST_IDX = LN'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [QW-1:0] r_pbuf [N];
  logic [UW-1:0] r_ubuf [N];
  logic [QW-1:0] r_acc  [N];
  logic [QW-1:0] w_acc_nxt [N];

  logic [LN-1:0] r_p_cnt;
  logic [LN-1:0] r_u_cnt;
  logic          r_p_done;
  logic          r_u_done;
  logic [LN-1:0] r_i;
  logic [LN-1:0] r_o_idx;
  logic          r_err;

  logic w_p_fire, w_u_fire;
  logic w_p_close, w_u_close;
  logic w_p_bad, w_u_bad;
  logic w_load_exit;
  logic w_compute_end;
  logic w_z_fire;
  logic w_drain_end;

  // A stream closes on its last flag or on its N-th beat, whichever comes
  // first; a mismatch between the two is a framing error.
  always_comb begin
    w_p_fire      = p_vld && p_rdy;
    w_u_fire      = u_vld && u_rdy;
    w_p_close     = w_p_fire && (p_last || (r_p_cnt == LAST_IDX));
    w_u_close     = w_u_fire && (u_last || (r_u_cnt == LAST_IDX));
    w_p_bad       = w_p_fire && (p_last != (r_p_cnt == LAST_IDX));
    w_u_bad       = w_u_fire && (u_last != (r_u_cnt == LAST_IDX));
    w_load_exit   = (r_state == ST_LOAD) && (r_p_done || w_p_close)
                    && (r_u_done || w_u_close);
    w_compute_end = (r_state == ST_COMPUTE) && (r_i == LAST_IDX);
    w_z_fire      = z_vld && z_rdy;
    w_drain_end   = w_z_fire && z_last;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (s_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = ST_LOAD;
      ST_LOAD:    if (w_load_exit)   w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (w_compute_end) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_drain_end)   w_state_nxt = ST_LOAD;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the state and the per-stream progress registers.
  always_comb begin
    p_rdy     = (r_state == ST_LOAD) && !r_p_done;
    u_rdy     = (r_state == ST_LOAD) && !r_u_done;
    z_vld     = (r_state == ST_DRAIN);
    z_last    = z_vld && (r_o_idx == LAST_IDX);
    z         = z_vld ? r_acc[r_o_idx] : '0;
    busy      = (r_state == ST_COMPUTE) || (r_state == ST_DRAIN);
    err       = r_err;
    dbg_state = r_state;
  end

  // Input capture. Buffers are zeroed when COMPUTE finishes so that a stream
  // closed early by its last flag leaves zeros in the unfilled slots.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_p_cnt  <= '0;
      r_u_cnt  <= '0;
      r_p_done <= 1'b0;
      r_u_done <= 1'b0;
      for (int j = 0; j < N; j++) begin
        r_pbuf[j] <= '0;
        r_ubuf[j] <= '0;
      end
    end else begin
      if (w_p_fire) begin
        r_pbuf[r_p_cnt] <= p;
        r_p_cnt         <= r_p_cnt + 1'b1;
        if (w_p_close) r_p_done <= 1'b1;
      end
      if (w_u_fire) begin
        r_ubuf[r_u_cnt] <= u;
        r_u_cnt         <= r_u_cnt + 1'b1;
        if (w_u_close) r_u_done <= 1'b1;
      end
      if (w_load_exit) begin
        r_p_cnt  <= '0;
        r_u_cnt  <= '0;
        r_p_done <= 1'b0;
        r_u_done <= 1'b0;
      end
      if (w_compute_end) begin
        for (int j = 0; j < N; j++) begin
          r_pbuf[j] <= '0;
          r_ubuf[j] <= '0;
        end
      end
    end
  end

  // Framing error pulse, one cycle after the offending beat.
  always_ff @(posedge clk) begin
    if (s_rst) r_err <= 1'b0;
    else       r_err <= w_p_bad || w_u_bad;
  end

  // One lane per output coefficient: in step i lane k adds p[i]*u[k-i],
  // negated when the index wraps past x^N (since x^N = -1).
  for (genvar k = 0; k < N; k++) begin : g_mac
    logic [LN-1:0]       w_idx;
    logic signed [W-1:0] w_prod;
    logic signed [W-1:0] w_sum;
    logic signed [W-1:0] w_rem;
    logic signed [W-1:0] w_fix;

    // Signed multiply-accumulate followed by an exact reduction into [0, Q).
    always_comb begin
      w_idx  = LN'(k) - r_i;
      w_prod = $signed({{(W-QW){1'b0}}, r_pbuf[r_i]})
             * $signed({{(W-UW){r_ubuf[w_idx][UW-1]}}, r_ubuf[w_idx]});
      if (LN'(k) >= r_i) w_sum = $signed({{(W-QW){1'b0}}, r_acc[k]}) + w_prod;
      else               w_sum = $signed({{(W-QW){1'b0}}, r_acc[k]}) - w_prod;
      w_rem  = w_sum % Q_S;
      w_fix  = w_rem[W-1] ? (w_rem + Q_S) : w_rem;
      w_acc_nxt[k] = w_fix[QW-1:0];
    end
  end

  // Step counter for COMPUTE; wraps back to zero as COMPUTE ends.
  always_ff @(posedge clk) begin
    if (s_rst)                         r_i <= '0;
    else if (r_state == ST_COMPUTE)    r_i <= r_i + 1'b1;
  end

  // Accumulators: cleared entering COMPUTE, updated every COMPUTE cycle,
  // held during DRAIN so stalled output stays stable.
  always_ff @(posedge clk) begin
    if (s_rst || w_load_exit) begin
      for (int j = 0; j < N; j++) r_acc[j] <= '0;
    end else if (r_state == ST_COMPUTE) begin
      for (int j = 0; j < N; j++) r_acc[j] <= w_acc_nxt[j];
    end
  end

  // Output index, advanced only on an accepted z beat.
  always_ff @(posedge clk) begin
    if (s_rst)         r_o_idx <= '0;
    else if (w_z_fire) r_o_idx <= r_o_idx + 1'b1;
  end

endmodule

// File: tb/tb_negacyclic_mult.sv
// Bench for negacyclic_mult: directed vectors, randomised frames with input
// gaps and output stalls, framing errors and mid-frame resets, all checked
// against a schoolbook negacyclic product model.
module tb_negacyclic_mult;
  localparam int N  = 4;
  localparam int QW = 5;
  localparam int UW = 2;
  localparam int Q  = 17;

  logic          clk;
  logic          s_rst;
  logic          p_vld, p_rdy, p_last;
  logic [QW-1:0] p;
  logic          u_vld, u_rdy, u_last;
  logic [UW-1:0] u;
  logic          z_vld, z_rdy, z_last;
  logic [QW-1:0] z;
  logic          err, busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int err_cnt = 0;

  int f_p [N];
  int f_u [N];
  int f_exp [N];
  int f_plast_at, f_ulast_at;
  bit f_plast_en, f_ulast_en;
  int p_acc_cyc, u_acc_cyc, first_vld_cyc;

  logic [QW-1:0] exp_q [$];

  negacyclic_mult #(.N(N), .QW(QW), .UW(UW), .Q(Q)) dut (
    .clk(clk), .s_rst(s_rst),
    .p_vld(p_vld), .p_rdy(p_rdy), .p(p), .p_last(p_last),
    .u_vld(u_vld), .u_rdy(u_rdy), .u(u), .u_last(u_last),
    .z_vld(z_vld), .z_rdy(z_rdy), .z(z), .z_last(z_last),
    .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter / err pulse counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (err === 1'b1) err_cnt++;

  function automatic bit p_bad();
    return !f_plast_en || (f_plast_at < N - 1);
  endfunction

  function automatic bit u_bad();
    return !f_ulast_en || (f_ulast_at < N - 1);
  endfunction

  task automatic set_full_frame();
    f_plast_en = 1; f_plast_at = N - 1;
    f_ulast_en = 1; f_ulast_at = N - 1;
  endtask

  task automatic randomize_frame();
    for (int b = 0; b < N; b++) begin
      f_p[b] = $urandom_range(0, Q - 1);
      f_u[b] = $urandom_range(0, 3) - 2;
    end
  endtask

  // Driver for the p stream; sends beats up to the closing beat.
  task automatic drive_p(input int gap_pct);
    int last_b;
    bit ok;
    int waited;
    last_b = f_plast_en ? f_plast_at : N - 1;
    for (int b = 0; b <= last_b; b++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        p_vld = 0; @(posedge clk); #1;
      end
      p_vld = 1; p = QW'(f_p[b]); p_last = f_plast_en && (b == f_plast_at);
      ok = 0; waited = 0;
      while (!ok && waited < 300) begin
        @(negedge clk);
        if (p_rdy === 1'b1) begin ok = 1; p_acc_cyc = cyc; end
        @(posedge clk); #1; waited++;
      end
      if (!ok) begin
        n_checks++; n_errors++;
        $display("FAIL p_accept_timeout beat=%0d p_rdy=%b required 1", b, p_rdy);
        p_vld = 0; p_last = 0;
        return;
      end
    end
    p_vld = 0; p_last = 0;
    @(negedge clk);
    n_checks++;
    if (p_rdy !== 1'b0) begin
      n_errors++; $display("FAIL p_rdy_drop got=%b required 0", p_rdy);
    end
    if (p_bad()) begin
      n_checks++;
      if (err !== 1'b1) begin
        n_errors++; $display("FAIL p_err_timing got=%b required 1", err);
      end
    end
  endtask

  // Driver for the u stream.
  task automatic drive_u(input int gap_pct);
    int last_b;
    bit ok;
    int waited;
    last_b = f_ulast_en ? f_ulast_at : N - 1;
    for (int b = 0; b <= last_b; b++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        u_vld = 0; @(posedge clk); #1;
      end
      u_vld = 1; u = UW'(f_u[b]); u_last = f_ulast_en && (b == f_ulast_at);
      ok = 0; waited = 0;
      while (!ok && waited < 300) begin
        @(negedge clk);
        if (u_rdy === 1'b1) begin ok = 1; u_acc_cyc = cyc; end
        @(posedge clk); #1; waited++;
      end
      if (!ok) begin
        n_checks++; n_errors++;
        $display("FAIL u_accept_timeout beat=%0d u_rdy=%b required 1", b, u_rdy);
        u_vld = 0; u_last = 0;
        return;
      end
    end
    u_vld = 0; u_last = 0;
    @(negedge clk);
    n_checks++;
    if (u_rdy !== 1'b0) begin
      n_errors++; $display("FAIL u_rdy_drop got=%b required 0", u_rdy);
    end
    if (u_bad()) begin
      n_checks++;
      if (err !== 1'b1) begin
        n_errors++; $display("FAIL u_err_timing got=%b required 1", err);
      end
    end
  endtask

  // Scoreboard side: accepts z beats with random back-pressure.
  task automatic collect(input int stall_pct);
    int got, waited;
    bit prev_stall, seen_vld;
    logic [QW-1:0] prev_z, exp_z;
    logic prev_last;
    got = 0; waited = 0; prev_stall = 0; seen_vld = 0;
    prev_z = '0; prev_last = 0;
    z_rdy = ($urandom_range(0, 99) >= stall_pct);
    while (got < N && waited < 400) begin
      @(negedge clk);
      if (z_vld === 1'b1 && !seen_vld) begin seen_vld = 1; first_vld_cyc = cyc; end
      if (prev_stall) begin
        n_checks++;
        if (z_vld !== 1'b1 || z !== prev_z || z_last !== prev_last) begin
          n_errors++;
          $display("FAIL stall_hold vld=%b z=%0d last=%b required vld=1 z=%0d last=%b",
                   z_vld, z, z_last, prev_z, prev_last);
        end
      end
      if (z_vld === 1'b1 && z_rdy) begin
        exp_z = exp_q.pop_front();
        n_checks++;
        if (z !== exp_z) begin
          n_errors++; $display("FAIL z_value beat=%0d got=%0d required %0d", got, z, exp_z);
        end
        n_checks++;
        if (z_last !== (got == N - 1)) begin
          n_errors++; $display("FAIL z_last beat=%0d got=%b required %b", got, z_last, (got == N - 1));
        end
        got++;
      end
      prev_stall = (z_vld === 1'b1) && !z_rdy;
      prev_z = z; prev_last = z_last;
      @(posedge clk); #1; waited++;
      z_rdy = ($urandom_range(0, 99) >= stall_pct);
    end
    z_rdy = 0;
    if (got < N) begin
      n_checks++; n_errors++;
      $display("FAIL z_timeout beats got=%0d required %0d", got, N);
      exp_q.delete();
    end
  endtask

  // Full frame: model, drive, collect, check latency and err count.
  task automatic run_frame(input int gap_pct, input int stall_pct, input bit use_model);
    int pe [N];
    int acc [N];
    int e0, n_err_exp, lat_ref;
    for (int b = 0; b < N; b++) begin
      pe[b] = (!f_plast_en || b <= f_plast_at) ? f_p[b] : 0;
      acc[b] = 0;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (f_ulast_en && j > f_ulast_at) continue;
        if (i + j < N) acc[i + j] += pe[i] * f_u[j];
        else           acc[i + j - N] -= pe[i] * f_u[j];
      end
    for (int k = 0; k < N; k++) begin
      if (use_model) exp_q.push_back(QW'(((acc[k] % Q) + Q) % Q));
      else           exp_q.push_back(QW'(f_exp[k]));
    end
    n_err_exp = int'(p_bad()) + int'(u_bad());
    e0 = err_cnt;
    first_vld_cyc = -1000;
    fork
      drive_p(gap_pct);
      drive_u(gap_pct);
      collect(stall_pct);
    join
    lat_ref = (p_acc_cyc > u_acc_cyc) ? p_acc_cyc : u_acc_cyc;
    n_checks++;
    if (first_vld_cyc - lat_ref != N + 1) begin
      n_errors++;
      $display("FAIL latency got=%0d required %0d", first_vld_cyc - lat_ref, N + 1);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_cnt - e0 != n_err_exp) begin
      n_errors++; $display("FAIL err_count got=%0d required %0d", err_cnt - e0, n_err_exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    s_rst = 1; p_vld = 0; u_vld = 0; p_last = 0; u_last = 0;
    repeat (2) @(posedge clk);
    #1 s_rst = 0;
  endtask

  task automatic check_quiet(input string name);
    bit quiet;
    quiet = 1;
    repeat (3 * N + 4) begin
      @(negedge clk);
      if (z_vld !== 1'b0) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin
      n_errors++; $display("FAIL %s stale z_vld seen after reset, required none", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    s_rst = 1; p_vld = 0; u_vld = 0; p_last = 0; u_last = 0; p = '0; u = '0; z_rdy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (p_rdy !== 1'b0)  begin n_errors++; $display("FAIL rst_p_rdy got=%b required 0", p_rdy); end
    n_checks++; if (u_rdy !== 1'b0)  begin n_errors++; $display("FAIL rst_u_rdy got=%b required 0", u_rdy); end
    n_checks++; if (z_vld !== 1'b0)  begin n_errors++; $display("FAIL rst_z_vld got=%b required 0", z_vld); end
    n_checks++; if (z_last !== 1'b0) begin n_errors++; $display("FAIL rst_z_last got=%b required 0", z_last); end
    n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL rst_err got=%b required 0", err); end
    n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL rst_busy got=%b required 0", busy); end
    n_checks++; if (z !== '0)        begin n_errors++; $display("FAIL rst_z got=%0d required 0", z); end
    @(posedge clk); #1 s_rst = 0;
    @(negedge clk);
    n_checks++;
    if (p_rdy !== 1'b0 || u_rdy !== 1'b0) begin
      n_errors++; $display("FAIL idle_cycle_rdy got=%b%b required 00", p_rdy, u_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (p_rdy !== 1'b1 || u_rdy !== 1'b1) begin
      n_errors++; $display("FAIL first_load_rdy got=%b%b required 11", p_rdy, u_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    set_full_frame();
    f_p = '{1, 0, 0, 0}; f_u = '{1, -1, 0, 1}; f_exp = '{1, 16, 0, 1};
    run_frame(0, 0, 0);
    f_p = '{0, 0, 0, 1}; f_u = '{0, 1, 0, 0}; f_exp = '{16, 0, 0, 0};
    run_frame(0, 0, 0);
  endtask

  task automatic test_random();
    set_full_frame();
    for (int t = 0; t < 8; t++) begin
      randomize_frame();
      run_frame(30, 40, 1);
    end
  endtask

  task automatic test_framing();
    set_full_frame();
    randomize_frame();
    f_plast_at = 1;
    run_frame(20, 20, 1);
    set_full_frame();
    randomize_frame();
    f_ulast_at = 2;
    run_frame(20, 20, 1);
    set_full_frame();
    randomize_frame();
    f_plast_en = 0;
    run_frame(20, 20, 1);
    set_full_frame();
  endtask

  task automatic test_reset_mid_frame();
    int waited;
    set_full_frame();
    randomize_frame();
    fork drive_p(0); drive_u(0); join
    waited = 0;
    while (busy !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    pulse_reset();
    check_quiet("rst_in_compute");
    randomize_frame();
    fork drive_p(0); drive_u(0); join
    waited = 0;
    while (z_vld !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    n_checks++;
    if (z_vld !== 1'b1) begin
      n_errors++; $display("FAIL drain_reach z_vld=%b required 1", z_vld);
    end
    repeat (3) @(posedge clk);
    pulse_reset();
    check_quiet("rst_in_drain");
    f_p = '{1, 1, 1, 1}; f_u = '{1, 1, 1, 1}; f_exp = '{15, 0, 2, 4};
    run_frame(0, 30, 0);
  endtask

  task automatic test_back_to_back();
    set_full_frame();
    f_p = '{16, 16, 16, 16}; f_u = '{-2, -2, -2, -2};
    run_frame(0, 0, 1);
    f_p = '{3, 0, 5, 0}; f_u = '{0, 1, 0, -1};
    run_frame(0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_framing();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/negacyclic_mult.md
NEGACYCLIC_MULT -- requirements
Module: negacyclic_mult

Interface
REQ-001 SHALL have parameter N, default 4: coefficients per polynomial; power of two, >= 2.
REQ-002 SHALL have parameter QW, default 5: bit-width of p and z coefficients.
REQ-003 SHALL have parameter UW, default 2: bit-width of u coefficients, signed two's complement.
REQ-004 SHALL have parameter Q, default 17: coefficient modulus, 2 <= Q <= 2**QW-1.
REQ-005 SHALL have port clk  in  1: single clock, all logic on its rising edge.
REQ-006 SHALL have port s_rst  in  1: reset, synchronous and active-high.
REQ-007 SHALL have ports p_vld in 1, p_rdy out 1, p in QW, p_last in 1: AXI-stream input of p coefficients, index 0 first.
REQ-008 SHALL have ports u_vld in 1, u_rdy out 1, u in UW, u_last in 1: AXI-stream input of u coefficients, index 0 first.
REQ-009 SHALL have ports z_vld out 1, z_rdy in 1, z out QW, z_last out 1: AXI-stream output of z = p*u mod (x^N+1, Q), index 0 first.
REQ-010 SHALL have port err  out  1: one-cycle pulse on framing error.
REQ-011 SHALL have port busy  out  1: high in COMPUTE and DRAIN.

Function
REQ-012 SHALL implement states IDLE, LOAD, COMPUTE, DRAIN; IDLE lasts one cycle, then LOAD.
REQ-013 In LOAD, p_rdy SHALL be high until N p beats are taken, u_rdy likewise for u; streams are independent, each with its own index counter and buffer.
REQ-014 A beat SHALL be accepted only on vld && rdy; p and u beats in the same cycle SHALL both be accepted.
REQ-015 LOAD SHALL exit to COMPUTE in the cycle after both streams are complete; accumulators acc[0..N-1] SHALL be cleared on that transition.
REQ-016 Early last (last on beat k < N-1): stream SHALL close, remaining coefficients zero-filled, err pulsed one cycle later.
REQ-017 Missing last (beat N-1 without last): stream SHALL close anyway, rdy drop, err pulsed one cycle later.
REQ-018 COMPUTE SHALL last exactly N cycles; in cycle i, for every k in parallel: acc[k] <= (acc[k] + s*p[i]*u[(k-i) mod N]) mod Q, s = +1 if k >= i, else -1.
REQ-019 Accumulators SHALL stay in [0, Q) after every update; reduction SHALL be exact for any signed u and p in [0, Q).
REQ-020 p >= Q is out of contract; z then unspecified, no hang.
REQ-021 DRAIN SHALL present acc[0..N-1] in order with z_vld high; index advances only on z_vld && z_rdy.
REQ-022 z, z_last SHALL hold stable while z_vld && !z_rdy.
REQ-023 z_last SHALL be high exactly with index N-1.
REQ-024 After the z_last handshake, state SHALL be LOAD, rdy high the next cycle.
REQ-025 Latency: first z_vld SHALL rise N+1 cycles after the cycle accepting the final input beat.
REQ-026 p_rdy, u_rdy SHALL be low outside LOAD; inputs outside LOAD SHALL be ignored.
REQ-027 Throughput with z_rdy tied high: one frame per 3N+2 cycles worst case.

Reset
REQ-028 While s_rst high: state IDLE; p_rdy, u_rdy, z_vld, z_last, err, busy = 0; z = 0; counters, buffers, accumulators = 0.
REQ-029 Reset in any state, including mid-COMPUTE or stalled DRAIN, SHALL abort the frame with no output beat emitted afterwards.
REQ-030 First LOAD cycle SHALL be the second cycle after s_rst deasserts.

Verification (N=4, Q=17, QW=5, UW=2)
REQ-031 p=[1,0,0,0], u=[1,-1,0,1] -> z=[1,16,0,1], z_last on 4th beat, err never high.
REQ-032 Negacyclic wrap: p=[0,0,0,1], u=[0,1,0,0] -> z=[16,0,0,0].
REQ-033 Random z_rdy stalls, random vld gaps on p and u independently -> z matches the software model, stable during every stall.
REQ-034 p_last on beat 1 -> err pulse, p treated as [p0,p1,0,0], result matches that model.
REQ-035 s_rst pulse during COMPUTE, then p=u=[1,1,1,1] -> no stale beat; z=[15,0,2,4].
REQ-036 Two back-to-back frames -> second result independent of first (accumulators cleared).
